sc_imem_loader: RTL and testbench
=================================

Name: sc_imem_loader

Overview:
- Serial program loader: the write side of the instruction memory that sc_cpu fetches from.
- Receives a framed 8N1 UART byte stream on rxd and assembles 32-bit little-endian words.
- Writes the words into instruction memory starting at word address 0.
- Holds the CPU in reset while a load is in progress, and keeps it there after a failed load.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
- ADDR_W, 6, width of the instruction-memory word address.
- TIMEOUT, 500000, idle cycles allowed between bytes mid-frame before the frame is aborted.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- rxd  in  1  UART receive line; idle high; asynchronous to clock.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_resetn  out  1  active-low reset to sc_cpu.
- busy  out  1  high while a frame is being received.
- load_ok  out  1  sticky: last frame completed with a good checksum.
- load_err  out  1  sticky: last frame aborted or checksum bad.

Behaviour:
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_resetn=1, busy=0, load_ok=0, load_err=0, FSM=IDLE, receiver idle. The CPU runs whatever program is preloaded.
- Receiver, rxd path:
  - rxd passes through a 2-flop synchronizer before any use.
  - A high-to-low transition while the receiver is idle starts a bit timer.
  - At CLKS_PER_BIT/2 the line is re-sampled. If it is high, this is a false start and the receiver returns to idle.
- Receiver, byte capture:
  - 8 data bits are sampled LSB first, each CLKS_PER_BIT apart.
  - The stop bit is then sampled.
  - Stop=1: a one-cycle internal byte_valid pulse with the byte.
  - Stop=0: framing error; no byte_valid.
- Frame format: 0xA5 header, then N (word count; 0 means 256), then 4*N data bytes (LSB first per word), then a checksum byte equal to the XOR of all data bytes.
- FSM states:
  - IDLE: bytes other than 0xA5 are ignored. On 0xA5 go to COUNT; busy=1, cpu_resetn=0, load_ok=0, load_err=0, imem_addr=0, running XOR=0.
  - COUNT: the next byte loads the word counter; go to DATA.
  - DATA: shift each byte into the word assembly register and XOR it into the checksum.
    - On the 4th byte of a word, imem_we=1 for exactly one cycle, presented the cycle after that byte's byte_valid.
    - imem_wdata and imem_addr are stable during that cycle.
    - imem_addr increments in the cycle after the strobe, wrapping modulo 2^ADDR_W.
    - After the last word go to CHECK.
  - CHECK: compare the received byte with the running XOR.
    - Equal: load_ok=1, cpu_resetn=1.
    - Unequal: load_err=1, cpu_resetn stays 0.
    - Either way busy=0 and return to IDLE.
- Abort: a framing error or TIMEOUT idle cycles in COUNT/DATA/CHECK sets load_err=1, busy=0, returns to IDLE, and keeps cpu_resetn=0. Words already written stay in memory.
- Header mid-frame: 0xA5 received in DATA is treated as data, never as a restart.
- CPU hold: cpu_resetn is released only by a successful CHECK or by the next resetn assertion.
- Async reset mid-frame: immediately returns every output to its reset value, including cpu_resetn=1, and discards any partial byte or word.
- Word count above 2^ADDR_W: writes wrap onto low addresses; this is not an error.

Test Plan:
- CLKS_PER_BIT=4, frame A5 01 13 00 02 24 35 -> exactly one imem_we pulse with imem_addr=0, imem_wdata=0x24020013; then load_ok=1, load_err=0, cpu_resetn rises to 1, busy falls.
- Frame A5 02 with 8 data bytes 11 22 33 44 55 66 77 88 and checksum 0x88 -> writes 0x44332211@0 and 0x88776655@1; load_ok=1. Repeat with checksum 0x00 -> same two writes, load_err=1, cpu_resetn stays 0.
- Frame A5 01 with data byte 2 sent with stop bit 0 -> no imem_we; load_err=1; busy=0; cpu_resetn=0. A following good frame restores cpu_resetn=1.
- 0.5-bit low glitch on rxd, then bytes 0x00 0xFF while IDLE -> no state change; cpu_resetn=1; busy=0.
- TIMEOUT=100; A5 02 and 4 data bytes, then silence -> one write at address 0, then load_err=1 after 100 idle cycles.
- resetn pulsed low during DATA -> all outputs return to reset values asynchronously (cpu_resetn=1, imem_addr=0); the next frame loads starting at address 0.

Source files
------------

// File: rtl/sc_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sc_imem_loader
//  Description : Serial program loader. Receives 8N1 UART frames
//                (A5, N, 4*N data bytes, XOR checksum) and writes 32-bit
//                little-endian words into instruction memory from address 0,
//                holding sc_cpu in reset while a load is in flight or failed.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_imem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 6,
    parameter int TIMEOUT      = 500000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              rxd,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_resetn,
    output logic              busy,
    output logic              load_ok,
    output logic              load_err
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0] c_half_bit = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_full_bit = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_TO_W-1:0]  c_to_last  = c_TO_W'(TIMEOUT - 1);
    localparam logic [7:0]         c_header   = 8'hA5;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t          r_rx_state;
    rx_state_t          w_rx_next;
    logic               r_rxd_meta;
    logic               r_rxd_sync;
    logic               r_rxd_prev;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_byte_valid;
    logic               r_frame_err;
    logic               w_tick_half;
    logic               w_tick_full;

    assign w_tick_half = (r_bit_cnt == c_half_bit);
    assign w_tick_full = (r_bit_cnt == c_full_bit);

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // Receiver state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    // Receiver next state: start edge, mid-start validation, 8 bits, stop.
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rxd_prev && !r_rxd_sync) w_rx_next = RX_START;
            RX_START: if (w_tick_half) w_rx_next = r_rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick_full && (r_bit_idx == 3'd7)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_tick_full) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // Bit timer, LSB-first shift register and byte/framing-error pulses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_bit_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_bit_cnt <= '0;
                end
                RX_START: begin
                    if (w_tick_half) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_tick_full) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        r_shift   <= {r_rxd_sync, r_shift[7:1]};
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_tick_full) begin
                        r_bit_cnt    <= '0;
                        r_byte_valid <= r_rxd_sync;
                        r_frame_err  <= ~r_rxd_sync;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_bit_cnt <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame parser / memory writer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } ld_state_t;

    ld_state_t         r_state;
    ld_state_t         w_next;
    logic [8:0]        r_words_left;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word;
    logic [7:0]        r_csum;
    logic [c_TO_W-1:0] r_idle_cnt;
    logic              w_header;
    logic              w_abort;
    logic              w_last_word;

    assign w_header    = r_byte_valid && (r_shift == c_header);
    assign w_abort     = (r_state != ST_IDLE) &&
                         (r_frame_err || (!r_byte_valid && (r_idle_cnt == c_to_last)));
    assign w_last_word = (r_state == ST_DATA) && r_byte_valid &&
                         (r_byte_idx == 2'd3) && (r_words_left == 9'd1);

    // Parser state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Parser next state; an abort overrides everything else.
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_header) w_next = ST_COUNT;
                ST_COUNT: if (r_byte_valid) w_next = ST_DATA;
                ST_DATA:  if (w_last_word) w_next = ST_CHECK;
                ST_CHECK: if (r_byte_valid) w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // Word assembly, checksum, write strobe, address and status flags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_resetn   <= 1'b1;
            busy         <= 1'b0;
            load_ok      <= 1'b0;
            load_err     <= 1'b0;
            r_words_left <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_csum       <= '0;
            r_idle_cnt   <= '0;
        end else begin
            imem_we <= 1'b0;
            // Address advances the cycle after each strobe.
            if (imem_we) begin
                imem_addr <= imem_addr + 1'b1;
            end
            if ((r_state == ST_IDLE) || r_byte_valid) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            if (w_abort) begin
                load_err   <= 1'b1;
                busy       <= 1'b0;
                cpu_resetn <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_header) begin
                            busy       <= 1'b1;
                            cpu_resetn <= 1'b0;
                            load_ok    <= 1'b0;
                            load_err   <= 1'b0;
                            imem_addr  <= '0;
                            r_csum     <= '0;
                            r_byte_idx <= '0;
                        end
                    end
                    ST_COUNT: begin
                        if (r_byte_valid) begin
                            // A count of zero stands for 256 words.
                            r_words_left <= (r_shift == 8'd0) ? 9'd256 : {1'b0, r_shift};
                        end
                    end
                    ST_DATA: begin
                        if (r_byte_valid) begin
                            r_csum     <= r_csum ^ r_shift;
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_word     <= {r_shift, r_word[23:8]};
                            if (r_byte_idx == 2'd3) begin
                                imem_we      <= 1'b1;
                                imem_wdata   <= {r_shift, r_word};
                                r_words_left <= r_words_left - 1'b1;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (r_byte_valid) begin
                            busy <= 1'b0;
                            if (r_shift == r_csum) begin
                                load_ok    <= 1'b1;
                                cpu_resetn <= 1'b1;
                            end else begin
                                load_err <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sc_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_imem_loader
//  Description : Self-checking bench for sc_imem_loader. A UART driver sends
//                directed and random frames; expected memory writes and load
//                status are derived from the frame contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_imem_loader;

    localparam int CPB = 4;
    localparam int AW  = 6;
    localparam int TO  = 100;

    logic          clock  = 1'b0;
    logic          resetn = 1'b0;
    logic          rxd    = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_resetn;
    logic          busy;
    logic          load_ok;
    logic          load_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [7:0]  frame_q[$];
    logic        prev_we = 1'b0;

    always #5 clock = ~clock;

    sc_imem_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .TIMEOUT      (TO)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .rxd        (rxd),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_resetn (cpu_resetn),
        .busy       (busy),
        .load_ok    (load_ok),
        .load_err   (load_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture every write strobe; a strobe must never last two cycles.
    always @(negedge clock) begin
        if (imem_we) begin
            check("we_one_cycle", 64'(prev_we), 64'd0);
            got_q.push_back({26'd0, imem_addr, imem_wdata});
        end
        prev_we <= imem_we;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clock) rxd = 1'b0;
        repeat (CPB - 1) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock) rxd = b[i];
            repeat (CPB - 1) @(negedge clock);
        end
        @(negedge clock) rxd = stop_bit;
        repeat (CPB - 1) @(negedge clock);
        @(negedge clock) rxd = 1'b1;
        repeat ($urandom_range(0, 6)) @(negedge clock);
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int k = 0;
        while (busy && (k < max_cycles)) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_busy_clear"}, 64'(busy), 64'd0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; (i < exp_q.size()) && (i < got_q.size()); i++) begin
            check({tag, "_write"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag, input logic ok, input logic err,
                                input logic cpu, input logic bsy);
        check({tag, "_load_ok"},    64'(load_ok),    64'(ok));
        check({tag, "_load_err"},   64'(load_err),   64'(err));
        check({tag, "_cpu_resetn"}, 64'(cpu_resetn), 64'(cpu));
        check({tag, "_busy"},       64'(busy),       64'(bsy));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_imem_we"},    64'(imem_we),    64'd0);
        check({tag, "_imem_addr"},  64'(imem_addr),  64'd0);
        check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Expected writes for the first n words of frame_q, little-endian,
    // addresses wrapping modulo the memory depth.
    task automatic expect_words(input int n);
        for (int w = 0; w < n; w++) begin
            exp_q.push_back({26'd0, AW'(w % (2 ** AW)),
                             frame_q[4*w+3], frame_q[4*w+2], frame_q[4*w+1], frame_q[4*w]});
        end
    endtask

    task automatic fill_random(input int n, input bit force_hdr);
        frame_q.delete();
        for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
        if (force_hdr) frame_q[$urandom_range(0, 4 * n - 1)] = 8'hA5;
    endtask

    // Send A5, count, frame_q contents and csum; check writes and outcome.
    task automatic frame_check(input string tag, input logic [7:0] csum);
        int          n = frame_q.size() / 4;
        logic [7:0]  x = 8'h00;
        logic        good;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        good = (x == csum);
        expect_words(n);
        send_byte(8'hA5, 1'b1);
        send_byte(8'(n), 1'b1);
        check_status({tag, "_inflight"}, 1'b0, 1'b0, 1'b0, 1'b1);
        foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
        send_byte(csum, 1'b1);
        wait_idle(tag, 200);
        check_writes(tag);
        check_status(tag, good, ~good, good, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs;

        // Reset state, both during and after reset.
        repeat (3) @(negedge clock);
        check_reset_vals("in_reset");
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        check_reset_vals("after_reset");

        // Half-bit glitch then non-header bytes while idle: nothing happens.
        @(negedge clock) rxd = 1'b0;
        repeat (CPB / 2) @(negedge clock);
        rxd = 1'b1;
        repeat (20) @(negedge clock);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (10) @(negedge clock);
        check_writes("glitch");
        check_status("glitch", 1'b0, 1'b0, 1'b1, 1'b0);

        // Single-word frame.
        frame_q = '{8'h13, 8'h00, 8'h02, 8'h24};
        frame_check("one_word", 8'h35);

        // Two words, good then bad checksum.
        frame_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        frame_check("two_good", 8'h88);
        frame_check("two_bad", 8'h00);

        // Framing error on the second data byte.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b0);
        wait_idle("frame_err", 200);
        check_writes("frame_err");
        check_status("frame_err", 1'b0, 1'b1, 1'b0, 1'b0);
        fill_random(2, 1'b0);
        cs = 8'h00;
        foreach (frame_q[i]) cs = cs ^ frame_q[i];
        frame_check("recover", cs);

        // Timeout after one word of a two-word frame.
        fill_random(1, 1'b0);
        expect_words(1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
        repeat (50) @(negedge clock);
        check_status("timeout_wait", 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle("timeout", 200);
        check_writes("timeout");
        check_status("timeout", 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of DATA.
        fill_random(2, 1'b0);
        expect_words(1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(frame_q[i], 1'b1);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clock) resetn = 1'b1;
        repeat (3) @(negedge clock);
        check_writes("async_reset");
        fill_random(3, 1'b0);
        cs = 8'h00;
        foreach (frame_q[i]) cs = cs ^ frame_q[i];
        frame_check("post_reset", cs);

        // Random frames, some with bad checksums or embedded header bytes.
        for (int t = 0; t < 6; t++) begin
            fill_random($urandom_range(1, 5), ($urandom_range(0, 1) == 1));
            cs = 8'h00;
            foreach (frame_q[i]) cs = cs ^ frame_q[i];
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            frame_check("random", cs);
        end

        // Word count larger than memory depth: addresses wrap.
        fill_random(70, 1'b1);
        cs = 8'h00;
        foreach (frame_q[i]) cs = cs ^ frame_q[i];
        frame_check("wrap", cs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
